// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
//   Shared definitions for the I2S receiver:
//     - default sample width and synchronizer depth
//     - register-map addresses for the 3-bit host address bus
//     - status bit positions in the status register
//     - receive FSM state encoding
// ---------------------------------------------------------------------------
package i2s_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SYNC_DEF  = 2;

    // Host register map
    localparam logic [2:0] ADDR_LL   = 3'd0;  // left  [7:0]  (reading also snapshots the pair)
    localparam logic [2:0] ADDR_LH   = 3'd1;  // left  [15:8] from snapshot
    localparam logic [2:0] ADDR_RL   = 3'd2;  // right [7:0]  from snapshot
    localparam logic [2:0] ADDR_RH   = 3'd3;  // right [15:8] from snapshot
    localparam logic [2:0] ADDR_STAT = 3'd4;  // {6'b0, short_err, pair_ready}

    // Status register bit positions
    localparam int STAT_PAIR  = 0;
    localparam int STAT_SHORT = 1;

    // Receive FSM
    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,  // waiting for the first word-select edge
        ST_DELAY = 2'd1,  // dropping the one-bit I2S delay slot
        ST_SHIFT = 2'd2,  // shifting in sample bits MSB first
        ST_SKIP  = 2'd3   // ignoring slot bits beyond the sample width
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
//   Brings an asynchronous 1-bit input into the clk domain through
//   SYNC_STAGES flops, followed by one edge register. The edge register
//   output is the delay-matched level; toggle flags the cycle in which the
//   synchronized value differs from it (the new value is ~level).
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low reset, clears the whole chain
//   din     in   asynchronous input
//   level   out  synchronized value after SYNC_STAGES+1 flops
//   toggle  out  one-clk pulse on any transition of din
// ---------------------------------------------------------------------------
module sync_edge
    import i2s_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic toggle
);

    // chain[SYNC_STAGES-1:0] are the synchronizer flops, chain[SYNC_STAGES]
    // is the edge register.
    logic [SYNC_STAGES:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-1:0], din};
        end
    end

    assign level  = chain[SYNC_STAGES];
    assign toggle = chain[SYNC_STAGES] ^ chain[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx
//   I2S receiver with a small host register interface. The bit clock, word
//   select and data are oversampled by clk; bits are taken on detected sck
//   rising edges. A left word followed by a right word in the same frame
//   updates left/right and pulses valid.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   sck    in   I2S bit clock
//   lrck   in   word select, 0 = left, 1 = right
//   sd     in   serial data, MSB first
//   left   out  last complete left sample
//   right  out  last complete right sample
//   valid  out  one-clk pulse when a new left/right pair is present
//   A      in   register address
//   din    in   register write data
//   wd     in   register write strobe (one clk)
//   dout   out  register read data, combinational from A
// ---------------------------------------------------------------------------
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sck,
    input  logic             lrck,
    input  logic             sd,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             valid,
    input  logic [2:0]       A,
    input  logic [7:0]       din,
    input  logic             wd,
    output logic [7:0]       dout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // ---------------- input synchronization ----------------
    logic sck_lvl, sck_tgl;
    logic lr_lvl, lr_tgl;
    logic [SYNC_STAGES:0] sd_chain;
    logic sd_bit;
    logic sck_rise;
    logic lr_edge;
    logic lr_new;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk    (clk),
        .reset  (reset),
        .din    (sck),
        .level  (sck_lvl),
        .toggle (sck_tgl)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk    (clk),
        .reset  (reset),
        .din    (lrck),
        .level  (lr_lvl),
        .toggle (lr_tgl)
    );

    // sd gets the same SYNC_STAGES+1 depth as the edge-register outputs of
    // sck/lrck, so on a detected sck rise sd_bit is the data value that was
    // present just before sck went high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sd_chain <= '0;
        end else begin
            sd_chain <= {sd_chain[SYNC_STAGES-1:0], sd};
        end
    end

    assign sd_bit   = sd_chain[SYNC_STAGES];
    assign sck_rise = sck_tgl & ~sck_lvl;
    assign lr_edge  = lr_tgl;
    assign lr_new   = ~lr_lvl;   // word-select value after the edge

    // ---------------- receive FSM ----------------
    state_t state, state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic shift_en, word_done, short_evt, cnt_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_ALIGN;
        end else begin
            state <= state_nxt;
        end
    end

    // A word-select edge always wins over an sck rise in the same clk.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ALIGN: begin
                if (lr_edge) state_nxt = ST_DELAY;
            end
            ST_DELAY: begin
                if (!lr_edge && sck_rise) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (lr_edge)
                    state_nxt = ST_DELAY;
                else if (sck_rise && bit_cnt == LAST_BIT)
                    state_nxt = ST_SKIP;
            end
            ST_SKIP: begin
                if (lr_edge) state_nxt = ST_DELAY;
            end
            default: state_nxt = ST_ALIGN;
        endcase
    end

    always_comb begin
        cnt_clr   = (state == ST_DELAY) && !lr_edge && sck_rise;
        shift_en  = (state == ST_SHIFT) && !lr_edge && sck_rise;
        word_done = shift_en && (bit_cnt == LAST_BIT);
        short_evt = (state == ST_SHIFT) && lr_edge;
    end

    // ---------------- word assembly and pairing ----------------
    // Only WIDTH-1 bits are stored: the final bit is appended on the fly
    // when the word completes.
    logic [WIDTH-2:0] shreg;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] left_hold;
    logic             chan;      // channel of the current slot, 1 = right
    logic             left_got;  // a left word completed in this frame

    assign word = {shreg, sd_bit};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            left_hold <= '0;
            chan      <= 1'b0;
            left_got  <= 1'b0;
            left      <= '0;
            right     <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;

            // A new left slot starts a new frame.
            if (lr_edge) begin
                chan <= lr_new;
                if (!lr_new) left_got <= 1'b0;
            end

            if (cnt_clr)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + CNT_W'(1);

            if (shift_en) shreg <= word[WIDTH-2:0];

            if (word_done) begin
                if (!chan) begin
                    left_hold <= word;
                    left_got  <= 1'b1;
                end else if (left_got) begin
                    left     <= left_hold;
                    right    <= word;
                    valid    <= 1'b1;
                    left_got <= 1'b0;
                end
            end
        end
    end

    // ---------------- host registers ----------------
    logic        pair_ready, short_err;
    logic [1:0]  clr;
    logic [15:0] left_v, right_v;
    logic [7:0]  snap_lh;
    logic [15:0] snap_r;
    logic        unused_din;

    assign clr        = (wd && A == ADDR_STAT) ? din[1:0] : 2'b00;
    assign unused_din = ^din[7:2];
    assign left_v     = 16'(left);
    assign right_v    = 16'(right);

    // Set has priority over a clear landing in the same clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pair_ready <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            pair_ready <= valid     | (pair_ready & ~clr[STAT_PAIR]);
            short_err  <= short_evt | (short_err  & ~clr[STAT_SHORT]);
        end
    end

    // Reading the low left byte freezes the rest of the pair so a multi-byte
    // read stays coherent across a new valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_lh <= '0;
            snap_r  <= '0;
        end else if (A == ADDR_LL) begin
            snap_lh <= left_v[15:8];
            snap_r  <= right_v;
        end
    end

    always_comb begin
        dout = 8'h00;
        case (A)
            ADDR_LL:   dout = left_v[7:0];
            ADDR_LH:   dout = snap_lh;
            ADDR_RL:   dout = snap_r[7:0];
            ADDR_RH:   dout = snap_r[15:8];
            ADDR_STAT: dout = {6'b0, short_err, pair_ready};
            default:   dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx
//   Self-checking bench for i2s_rx. An I2S transmitter task drives sck/lrck/sd
//   with a slot = one delay bit followed by the slot's data bits. A frame-level
//   reference model (plain queues and flags) predicts the pairs and status.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

    localparam int W = 16;
    localparam int H = 3;   // clk cycles per sck phase

    logic         clk = 1'b0;
    logic         reset;
    logic         sck, lrck, sd;
    logic [W-1:0] left, right;
    logic         valid;
    logic [2:0]   A;
    logic [7:0]   din;
    logic         wd;
    logic [7:0]   dout;

    always #5 clk = ~clk;

    i2s_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sck   (sck),
        .lrck  (lrck),
        .sd    (sd),
        .left  (left),
        .right (right),
        .valid (valid),
        .A     (A),
        .din   (din),
        .wd    (wd),
        .dout  (dout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0]  m_left_word;
    bit            m_left_done, m_pair_ready, m_short;
    logic [31:0]   exp_q[$];
    logic [31:0]   got_q[$];

    function automatic void model_reset();
        m_left_word  = '0;
        m_left_done  = 0;
        m_pair_ready = 0;
        m_short      = 0;
        exp_q.delete();
        got_q.delete();
    endfunction

    // One slot of 'len' data bits on channel ch (every slot in this bench is
    // followed by a word-select edge before status is examined).
    function automatic void model_slot(input logic ch, input logic [W-1:0] w, input int len);
        if (!ch) m_left_done = 0;
        if (len < W) begin
            m_short = 1;
        end else if (!ch) begin
            m_left_done = 1;
            m_left_word = w;
        end else if (m_left_done) begin
            exp_q.push_back({m_left_word, w});
            m_pair_ready = 1;
            m_left_done  = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && valid === 1'b1) got_q.push_back({left, right});
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_bit(input logic lr, input logic b);
        @(negedge clk);
        lrck = lr;
        sd   = b;
        repeat (H - 1) @(negedge clk);
        sck = 1'b1;
        repeat (H) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_slot(input logic ch, input logic [W-1:0] w, input int len, input logic trail);
        send_bit(ch, 1'($urandom_range(0, 1)));
        for (int i = 0; i < len; i++) send_bit(ch, (i < W) ? w[W-1-i] : trail);
        model_slot(ch, w, len);
    endtask

    task automatic send_frame(input logic [W-1:0] lw, input int llen,
                              input logic [W-1:0] rw, input int rlen, input logic trail);
        send_slot(1'b0, lw, llen, trail);
        send_slot(1'b1, rw, rlen, trail);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        A = a;
        @(posedge clk);
        #1 d = dout;
        A = 3'd7;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        reg_read(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        A   = a;
        din = d;
        wd  = 1'b1;
        @(negedge clk);
        wd  = 1'b0;
        A   = 3'd7;
        if (a == 3'd4) begin
            if (d[0]) m_pair_ready = 0;
            if (d[1]) m_short = 0;
        end
    endtask

    task automatic compare_pairs(input string tag);
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq({tag, "_pair"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    bit seen39;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len_tab[4];
        logic [W-1:0] w;
        len_tab = '{8, 16, 20, 32};

        reset = 1'b0; sck = 1'b0; lrck = 1'b1; sd = 1'b0;
        A = 3'd7; din = 8'h00; wd = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_left", left, 0);
        check_eq("rst_right", right, 0);
        check_eq("rst_valid", valid, 0);
        check_reg("rst_stat", 3'd4, 8'h00);
        check_reg("rst_a0", 3'd0, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Basic 16-bit frame
        send_frame(16'hA5C3, 16, 16'h1234, 16, 1'b0);
        settle();
        check_eq("f1_left", left, 16'hA5C3);
        check_eq("f1_right", right, 16'h1234);
        compare_pairs("f1");
        check_reg("f1_a0", 3'd0, 8'hC3);
        check_reg("f1_a1", 3'd1, 8'hA5);
        check_reg("f1_a2", 3'd2, 8'h34);
        check_reg("f1_a3", 3'd3, 8'h12);
        check_reg("f1_a4", 3'd4, 8'h01);
        check_reg("f1_a5", 3'd5, 8'h00);

        // 32-bit slots with trailing ones
        send_frame(16'h8001, 32, 16'h7FFE, 32, 1'b1);
        settle();
        check_eq("f32_left", left, 16'h8001);
        check_eq("f32_right", right, 16'h7FFE);
        compare_pairs("f32");

        // Short left word
        reg_write(3'd4, 8'h03);
        check_reg("short_pre", 3'd4, 8'h00);
        send_slot(1'b0, 16'hFFFF, 8, 1'b0);
        send_slot(1'b1, 16'h5A5A, 16, 1'b0);
        settle();
        compare_pairs("short");
        check_eq("short_left_kept", left, 16'h8001);
        check_reg("short_stat", 3'd4, 8'h02);
        reg_write(3'd4, 8'h02);
        check_reg("short_clr", 3'd4, 8'h00);

        // Clear of pair_ready in the same clk as valid
        reg_write(3'd4, 8'h03);
        seen39 = 0;
        fork
            send_frame(16'h1111, 16, 16'h2222, 16, 1'b0);
            begin
                for (int i = 0; i < 4000; i++) begin
                    @(negedge clk);
                    if (valid === 1'b1) begin
                        seen39 = 1;
                        A = 3'd4; din = 8'h01; wd = 1'b1;
                        @(negedge clk);
                        wd = 1'b0; A = 3'd7;
                        break;
                    end
                end
            end
        join
        check_eq("setwin_seen", seen39, 1);
        settle();
        compare_pairs("setwin");
        check_reg("setwin_stat", 3'd4, 8'h01);

        // Snapshot coherence across a new pair
        send_frame(16'hBEEF, 16, 16'hCAFE, 16, 1'b0);
        settle();
        compare_pairs("snapA");
        check_reg("snap_a0", 3'd0, 8'hEF);
        send_frame(16'h0F0F, 16, 16'hF0F0, 16, 1'b0);
        settle();
        check_eq("snap_new_left", left, 16'h0F0F);
        compare_pairs("snapB");
        check_reg("snap_a1", 3'd1, 8'hBE);
        check_reg("snap_a2", 3'd2, 8'hFE);
        check_reg("snap_a3", 3'd3, 8'hCA);
        check_reg("snap_live_a0", 3'd0, 8'h0F);

        // Reset in the middle of a left word
        w = 16'h1357;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b0, w[W-1-i]);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("mrst_left", left, 0);
        check_eq("mrst_right", right, 0);
        check_eq("mrst_valid", valid, 0);
        check_reg("mrst_stat", 3'd4, 8'h00);
        check_reg("mrst_a1", 3'd1, 8'h00);
        check_reg("mrst_a3", 3'd3, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 5; i < W; i++) send_bit(1'b0, w[W-1-i]);
        send_slot(1'b1, 16'h2468, 16, 1'b0);
        send_frame(16'h1357, 16, 16'h9BDF, 16, 1'b0);
        settle();
        check_eq("mrst_new_left", left, 16'h1357);
        check_eq("mrst_new_right", right, 16'h9BDF);
        compare_pairs("mrst");

        // Randomized frames
        reg_write(3'd4, 8'h03);
        for (int f = 0; f < 15; f++) begin
            int ll, rl;
            ll = len_tab[$urandom_range(0, 3)];
            rl = (f == 14) ? 16 + 16 * $urandom_range(0, 1) : len_tab[$urandom_range(0, 3)];
            send_frame(W'($urandom), ll, W'($urandom), rl, 1'($urandom_range(0, 1)));
        end
        settle();
        compare_pairs("rnd");
        check_reg("rnd_stat", 3'd4, {6'b0, m_short, m_pair_ready});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
